// File: rtl/register_dump_sequencer_if.sv
// Bundle between the register dump sequencer and its neighbours: start request,
// register-file debug read port, byte stream to the debug UART, and status.
interface register_dump_sequencer_if #(
  parameter int NB_DATA        = 32,
  parameter int NB_REG_ADDRESS = 5,
  parameter int NB_BYTE        = 8
);
  logic                      i_start;
  logic [NB_DATA-1:0]        i_dato_debug;
  logic [NB_REG_ADDRESS-1:0] o_direc_debug;
  logic [NB_BYTE-1:0]        o_tx_data;
  logic                      o_tx_valid;
  logic                      i_tx_ready;
  logic                      o_busy;
  logic                      o_halt;
  logic                      o_done;

  modport master (
    input  i_start, i_dato_debug, i_tx_ready,
    output o_direc_debug, o_tx_data, o_tx_valid, o_busy, o_halt, o_done
  );

  modport slave (
    output i_start, i_dato_debug, i_tx_ready,
    input  o_direc_debug, o_tx_data, o_tx_valid, o_busy, o_halt, o_done
  );
endinterface

// File: rtl/register_dump_sequencer.sv
// Walks the register file through its debug read port and streams every value
// MSB-byte first over a valid/ready byte link, halting the pipeline meanwhile.
module register_dump_sequencer #(
  parameter int NB_DATA        = 32,
  parameter int NB_REG_ADDRESS = 5,
  parameter int N_REGS         = 32,
  parameter int NB_BYTE        = 8
) (
  input logic                     i_clock,
  input logic                     i_reset,
  register_dump_sequencer_if.master bus
);
  localparam int N_BYTES = NB_DATA / NB_BYTE;
  localparam int CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [CNT_W-1:0]          LAST_BYTE = CNT_W'(N_BYTES - 1);
  localparam logic [NB_REG_ADDRESS-1:0] LAST_REG  = NB_REG_ADDRESS'(N_REGS - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LATCH,
    SEND,
    NEXT,
    DONE
  } state_t;

  state_t                    state, state_next;
  logic [NB_REG_ADDRESS-1:0] reg_idx, reg_idx_next;
  logic [CNT_W-1:0]          byte_cnt, byte_cnt_next;
  logic [NB_DATA-1:0]        shift_reg, shift_reg_next;

  // Reset clears the datapath as well so every output is zero while in reset.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state     <= IDLE;
      reg_idx   <= '0;
      byte_cnt  <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_next;
      reg_idx   <= reg_idx_next;
      byte_cnt  <= byte_cnt_next;
      shift_reg <= shift_reg_next;
    end
  end

  always_comb begin
    state_next     = state;
    reg_idx_next   = reg_idx;
    byte_cnt_next  = byte_cnt;
    shift_reg_next = shift_reg;
    case (state)
      IDLE: begin
        reg_idx_next = '0;
        if (bus.i_start) state_next = ADDR;
      end
      // ADDR only gives the register-file read one cycle to settle.
      ADDR: state_next = LATCH;
      LATCH: begin
        shift_reg_next = bus.i_dato_debug;
        byte_cnt_next  = '0;
        state_next     = SEND;
      end
      SEND: begin
        if (bus.i_tx_ready) begin
          shift_reg_next = shift_reg << NB_BYTE;
          byte_cnt_next  = byte_cnt + CNT_W'(1);
          if (byte_cnt == LAST_BYTE) state_next = NEXT;
        end
      end
      NEXT: begin
        if (reg_idx == LAST_REG) begin
          state_next = DONE;
        end else begin
          reg_idx_next = reg_idx + NB_REG_ADDRESS'(1);
          state_next   = ADDR;
        end
      end
      DONE: begin
        reg_idx_next = '0;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // All outputs decode registered state only; i_tx_ready never reaches them.
  assign bus.o_tx_valid    = (state == SEND);
  assign bus.o_tx_data     = (state == SEND) ? shift_reg[NB_DATA-1 -: NB_BYTE] : '0;
  assign bus.o_direc_debug = (state inside {ADDR, LATCH, SEND, NEXT}) ? reg_idx : '0;
  assign bus.o_busy        = (state != IDLE);
  assign bus.o_halt        = (state != IDLE);
  assign bus.o_done        = (state == DONE);

endmodule

// File: doc/register_dump_sequencer.md
Name: register_dump_sequencer

Overview:
Debug controller that owns the register file's debug read port in the instruction-decode stage. On a start request it walks register addresses 0..N_REGS-1 and captures each 32-bit value. It streams each value as NB_DATA/NB_BYTE bytes over a valid/ready byte interface toward the debug UART transmitter. While dumping, it asserts a halt to the pipeline so no register writes occur mid-dump.

Parameters:
NB_DATA, 32, width of a register value
NB_REG_ADDRESS, 5, width of debug read address
N_REGS, 32, registers dumped; must satisfy 1 <= N_REGS <= 2**NB_REG_ADDRESS
NB_BYTE, 8, width of output byte; NB_DATA must be a multiple of NB_BYTE

Ports:
i_clock  in  1  system clock, all logic on rising edge
i_reset  in  1  synchronous, active-low reset (0 = reset)
i_start  in  1  dump request, sampled only in IDLE
i_dato_debug  in  NB_DATA  register file debug read data (combinational read of o_direc_debug)
o_direc_debug  out  NB_REG_ADDRESS  register file debug read address
o_tx_data  out  NB_BYTE  byte to transmitter
o_tx_valid  out  1  o_tx_data valid
i_tx_ready  in  1  transmitter accepts byte when high with o_tx_valid
o_busy  out  1  high whenever state != IDLE
o_halt  out  1  pipeline halt; equals o_busy
o_done  out  1  one-cycle pulse at end of dump

Behaviour:
- Reset (i_reset==0 at a clock edge): state=IDLE, reg_idx=0, byte_cnt=0, shift register=0. All outputs are 0: o_direc_debug, o_tx_data, o_tx_valid, o_busy, o_halt, o_done.
- Outputs are Moore-decoded from registered state and registered datapath. No combinational path from i_tx_ready or i_start to any output.
- States: IDLE, ADDR, LATCH, SEND, NEXT, DONE.
- IDLE: on i_start=1, go to ADDR with reg_idx=0. Otherwise stay.
- ADDR: o_direc_debug=reg_idx (held from here through NEXT). One cycle for read settling, then go to LATCH.
- LATCH: shift register <= i_dato_debug, byte_cnt <= 0, then go to SEND.
- SEND: o_tx_valid=1. o_tx_data = most-significant byte of the shift register (big-endian: bits [NB_DATA-1 -: NB_BYTE]).
  - On o_tx_valid & i_tx_ready, shift left by NB_BYTE and increment byte_cnt.
  - After the transfer of byte NB_DATA/NB_BYTE-1, go to NEXT.
  - While i_tx_ready=0, o_tx_data and o_tx_valid stay stable.
- NEXT: if reg_idx==N_REGS-1, go to DONE. Otherwise reg_idx++ and go to ADDR.
- DONE: o_done=1 for exactly this cycle, then go to IDLE. reg_idx returns to 0 in IDLE.
- i_start while busy is ignored and not queued.
- i_start held high keeps retriggering: a new dump begins the cycle after IDLE is re-entered.
- Timing with i_tx_ready constantly 1 and N_REGS=32:
  - i_start seen in IDLE at cycle 0.
  - ADDR at cycle 1; first o_tx_valid at cycle 3.
  - Each register takes 7 cycles.
  - DONE at cycle 225; IDLE at cycle 226.
  - Exactly 128 bytes are sent.
- Reset mid-operation: abort immediately, return to IDLE. o_tx_valid drops in the reset cycle, no o_done pulse, partial stream is discarded.
- Register 0 is dumped like any other register; the sequencer does not special-case it.

Test Plan:
- Full dump, ready=1: register k preloaded with 0xA5000000+k, pulse i_start -> 128 bytes; bytes for r3 are A5,00,00,03. o_busy for cycles 1-225, o_done pulse at cycle 225.
- Backpressure: i_tx_ready random about 50% during the r1 value 0x12345678 -> bytes 12,34,56,78 in order. o_tx_data constant on every cycle with valid=1 & ready=0. No byte duplicated or lost.
- Start while busy: pulse i_start at cycles 1, 50 and 200 -> single dump of 128 bytes, one o_done.
- Reset mid-dump: drive i_reset=0 during the SEND of r5 byte 2 -> next cycle state IDLE with all outputs 0. A new i_start restarts from r0 byte 0.
- Continuous start: i_start tied 1 -> second dump's ADDR begins at cycle 227; o_done pulses 226 cycles apart.
- Parameter corner: N_REGS=1, ready=1 -> exactly 4 bytes, o_done at cycle 8, o_direc_debug stays 0 throughout.
